// File: rtl/button_debounce.sv
// button_debounce: synchronises WIDTH raw button pins into clk and debounces them
// on a shared prescaled tick. Outputs debounced levels plus one-cycle press and
// release strobes. Define AUTOREPEAT_EN to build per-channel auto-repeat strobes;
// without it btn_repeat is tied to 0 and no repeat counters exist.
// REPEAT_RATE must not exceed REPEAT_DELAY: later repeats reload the repeat
// counter to REPEAT_DELAY-REPEAT_RATE, so it never counts past REPEAT_DELAY-1.
module button_debounce #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_repeat
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_TICKS - 1);

  // Reject parameter sets the counters cannot represent.
  if (TICK_DIV < 2 || STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
    $error("button_debounce: illegal parameter combination");
  end

  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] sync_p2;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [STB_W-1:0] stable_cnt [WIDTH];
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] accept;

  // Two-flop synchroniser: raw pins -> sync_p1 -> sync_p2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= btn_in;
      sync_p2 <= sync_p1;
    end
  end

  // Free-running prescaler shared by every channel; wraps at TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick     = (pre_cnt == PRE_LAST);
  assign mismatch = sync_p2 ^ btn_level;

  // A channel is accepted on the tick that completes STABLE_TICKS differing ticks.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++)
      accept[i] = mismatch[i] && tick && (stable_cnt[i] == STB_LAST);
  end

  // Per-channel stability counters, debounced level and press/release strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < WIDTH; i++) stable_cnt[i] <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!mismatch[i]) begin
          stable_cnt[i] <= '0;
        end else if (accept[i]) begin
          btn_level[i]   <= sync_p2[i];
          btn_press[i]   <= sync_p2[i];
          btn_release[i] <= ~sync_p2[i];
          stable_cnt[i]  <= '0;
        end else if (tick) begin
          stable_cnt[i]  <= stable_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [RPT_W-1:0] rpt_cnt [WIDTH];

  // Auto-repeat: count held ticks from press; first strobe after REPEAT_DELAY
  // ticks, then every REPEAT_RATE ticks. Any transition or low level clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_repeat <= '0;
      for (int i = 0; i < WIDTH; i++) rpt_cnt[i] <= '0;
    end else begin
      btn_repeat <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (accept[i] || !btn_level[i]) begin
          rpt_cnt[i] <= '0;
        end else if (tick) begin
          if (rpt_cnt[i] == RPT_LAST) begin
            btn_repeat[i] <= 1'b1;
            rpt_cnt[i]    <= RPT_RELOAD;
          end else begin
            rpt_cnt[i]    <= rpt_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign btn_repeat = '0;
`endif

endmodule
